// File: rtl/button_debouncer.sv
// button_debouncer: qualifies a bouncy push-button level over STABLE_CYCLES clocks.
// Define DEBOUNCER_SYNC_EN to add a two-flop synchroniser on pb_raw.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned CNT_W         = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic pb_clean,
    output logic bouncing
);
    // Encoding is {pb_clean, bouncing}, so both outputs come straight from the state flops.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_e;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s;
`ifdef DEBOUNCER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], pb_raw};
    end
    assign s = sync_q[1];
`else
    assign s = pb_raw;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                state_d = s ? WAIT_HI : STABLE_LO;
                cnt_d   = s ? ONE : '0;
            end
            WAIT_HI: begin
                state_d = !s ? STABLE_LO : (cnt_q == LAST) ? STABLE_HI : WAIT_HI;
                cnt_d   = (!s || cnt_q == LAST) ? '0 : cnt_q + ONE;
            end
            STABLE_HI: begin
                state_d = !s ? WAIT_LO : STABLE_HI;
                cnt_d   = !s ? ONE : '0;
            end
            WAIT_LO: begin
                state_d = s ? STABLE_HI : (cnt_q == LAST) ? STABLE_LO : WAIT_LO;
                cnt_d   = (s || cnt_q == LAST) ? '0 : cnt_q + ONE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign pb_clean = state_q[1];
    assign bouncing = state_q[0];
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: randomized and directed scoreboard bench for button_debouncer.
module tb_button_debouncer;
    localparam int SC = 8;
`ifdef DEBOUNCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic clk = 0;
    logic rst = 0;
    logic pb_raw = 1;
    logic pb_clean, bouncing;
    int n_tests = 0;
    int n_fail = 0;
    logic [1:0] sb[$];
    bit pipe[$];
    bit hist[$];
    bit exp_clean;

    button_debouncer #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .pb_raw(pb_raw), .pb_clean(pb_clean), .bouncing(bouncing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: {pb_clean,bouncing} got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        exp_clean = 0;
        hist.delete();
        pipe.delete();
        for (int i = 0; i < LAT; i++) pipe.push_back(1'b0);
        sb.delete();
    endfunction

    // Reference: s is pb_raw delayed LAT edges; pb_clean flips once the last SC samples of s all disagree with it.
    task automatic model_step();
        bit s;
        int n;
        pipe.push_back(pb_raw);
        s = pipe.pop_front();
        hist.push_back(s);
        if (hist.size() > SC) void'(hist.pop_front());
        n = 0;
        foreach (hist[i]) if (hist[i] != exp_clean) n++;
        if (n == SC) exp_clean = !exp_clean;
        sb.push_back({exp_clean, s != exp_clean});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sb.delete();
            check("in_reset", {pb_clean, bouncing}, 2'b00);
        end else if (sb.size() > 0) begin
            check("track", {pb_clean, bouncing}, sb.pop_front());
        end
    end

    task automatic hold(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            pb_raw = v;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2 rst = 0;
        #1 check("reset_now", {pb_clean, bouncing}, 2'b00);
        hold(pb_raw, n);
        @(negedge clk);
        #2 rst = 1;
    endtask

    initial begin
        #3 check("reset_init", {pb_clean, bouncing}, 2'b00);
        hold(1, 3);
        @(negedge clk);
        #2 rst = 1;
        hold(1, 15);
        hold(0, 15);
        hold(1, 15);
        hold(0, 15);
        for (int i = 0; i < 10; i++) hold(i % 2 == 0, 3);
        hold(1, 15);
        hold(0, 15);
        hold(1, SC - 1);
        hold(0, 15);
        hold(1, SC);
        hold(0, 20);
        hold(1, LAT + 5);
        do_reset(2);
        hold(1, 15);
        hold(0, 15);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(0, 15);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
